rotary_led_mode_ctrl: RTL



---
 rtl/rotary_led_mode_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rotary_led_mode_ctrl.sv
// Rotary-encoder LED mode controller: manual position, auto-run at adjustable speed,
// and bar-graph level, selected by the centre button.
module rotary_led_mode_ctrl #(
  parameter int unsigned PRESCALE   = 5000000,
  parameter int unsigned PRESCALE_W = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rotation_event,
  input  logic       rotation_direction,
  input  logic       btn_press,
  output logic [7:0] led,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_AUTO   = 2'd1,
    MODE_BAR    = 2'd2
  } mode_e;

  mode_e                 mode_q, mode_d;
  logic [2:0]            pos_q, pos_d;
  logic [2:0]            speed_q, speed_d;
  logic [3:0]            level_q, level_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [2:0]            step_cnt_q, step_cnt_d;
  logic                  tick;

  assign tick = (presc_q == PRESCALE_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_MANUAL;
      pos_q      <= '0;
      speed_q    <= '0;
      level_q    <= '0;
      presc_q    <= '0;
      step_cnt_q <= '0;
    end else begin
      mode_q     <= mode_d;
      pos_q      <= pos_d;
      speed_q    <= speed_d;
      level_q    <= level_d;
      presc_q    <= presc_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  always_comb begin
    mode_d     = mode_q;
    pos_d      = pos_q;
    speed_d    = speed_q;
    level_d    = level_q;
    presc_d    = presc_q;
    step_cnt_d = step_cnt_q;

    // A button press takes the whole cycle: rotation and any coincident step are dropped.
    if (btn_press) begin
      case (mode_q)
        MODE_MANUAL: begin
          mode_d     = MODE_AUTO;
          presc_d    = '0;
          step_cnt_d = '0;
        end
        MODE_AUTO: mode_d = MODE_BAR;
        default:   mode_d = MODE_MANUAL;
      endcase
    end else begin
      case (mode_q)
        MODE_MANUAL: begin
          if (rotation_event) begin
            pos_d = rotation_direction ? pos_q + 3'd1 : pos_q - 3'd1;
          end
        end
        MODE_AUTO: begin
          presc_d = tick ? '0 : presc_q + PRESCALE_W'(1);
          // Step compare uses the speed held before this edge's rotation event.
          if (tick) begin
            if (step_cnt_q >= 3'd7 - speed_q) begin
              pos_d      = pos_q + 3'd1;
              step_cnt_d = '0;
            end else begin
              step_cnt_d = step_cnt_q + 3'd1;
            end
          end
          if (rotation_event) begin
            if (rotation_direction && speed_q != 3'd7) begin
              speed_d = speed_q + 3'd1;
            end else if (!rotation_direction && speed_q != 3'd0) begin
              speed_d = speed_q - 3'd1;
            end
          end
        end
        MODE_BAR: begin
          if (rotation_event) begin
            if (rotation_direction && level_q < 4'd8) begin
              level_d = level_q + 4'd1;
            end else if (!rotation_direction && level_q != 4'd0) begin
              level_d = level_q - 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    led = '0;
    if (mode_q == MODE_BAR) begin
      for (int unsigned i = 0; i < 8; i++) begin
        led[i] = (4'(i) < level_q);
      end
    end else begin
      led[pos_q] = 1'b1;
    end
  end

  assign mode = mode_q;

endmodule
